hard_mem_1rw_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one single-port (1RW) byte-masked hard memory wrapper, e.g. the 512x64 byte-mask instance.
- Clears the whole array after reset.
- Round-robins read and write requests from two clients onto the one memory port.
- Captures the 1-cycle SRAM read data into a per-client response register with a valid/yumi handshake.
- Sits between the frontend cache/tag logic and the memory wrapper.

---
 rtl/hard_mem_1rw_arbiter.sv | 138 +++++++++++++
 tb/tb_hard_mem_1rw_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hard_mem_1rw_arbiter.sv
// Two-client round-robin arbiter and clear sequencer for a 1RW byte-masked SRAM.
// Read data returns one cycle after grant and is held per client until yumi.
module hard_mem_1rw_arbiter #(
  parameter int ELS            = 512,
  parameter int WIDTH          = 64,
  parameter int ADDR_W         = $clog2(ELS),
  parameter int MASK_W         = WIDTH / 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [1:0]          v_i,
  input  logic [1:0]          w_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*WIDTH-1:0]  data_i,
  input  logic [2*MASK_W-1:0] mask_i,
  output logic [1:0]          ready_o,
  output logic [2*WIDTH-1:0]  data_o,
  output logic [1:0]          v_o,
  input  logic [1:0]          yumi_i,
  output logic                init_done_o,
  output logic                mem_v_o,
  output logic                mem_w_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [WIDTH-1:0]    mem_data_o,
  output logic [MASK_W-1:0]   mem_mask_o,
  input  logic [WIDTH-1:0]    mem_data_i
);

  typedef enum logic [1:0] {
    RST_WAIT,
    INIT,
    RUN
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               last_q, last_d;
  logic [1:0]         infl_q, infl_d;
  logic [1:0]         v_q, v_d;
  logic [2*WIDTH-1:0] data_q, data_d;

  logic       run;
  logic [1:0] elig;
  logic       gnt_v;
  logic       gnt_idx;

  assign run         = (state_q == RUN);
  assign init_done_o = run;
  assign v_o         = v_q;
  assign data_o      = data_q;

  // A read may only issue when its response slot is free or being freed now.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      elig[p] = run & v_i[p]
              & (w_i[p] | (~infl_q[p] & (~v_q[p] | yumi_i[p])));
    end
    gnt_v   = |elig;
    gnt_idx = (elig == 2'b11) ? ~last_q : elig[1];
    ready_o = 2'b00;
    if (gnt_v) begin
      ready_o = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_mask_o = '0;
    if (state_q == INIT) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = clr_cnt_q;
      mem_mask_o = '1;
    end else if (gnt_v) begin
      mem_v_o    = 1'b1;
      mem_w_o    = w_i[gnt_idx];
      mem_addr_o = gnt_idx ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
      mem_data_o = gnt_idx ? data_i[2*WIDTH-1:WIDTH] : data_i[WIDTH-1:0];
      mem_mask_o = gnt_idx ? mask_i[2*MASK_W-1:MASK_W] : mask_i[MASK_W-1:0];
    end
  end

  always_comb begin
    last_d = gnt_v ? gnt_idx : last_q;
    infl_d = ready_o & ~w_i;
    v_d    = v_q;
    data_d = data_q;
    for (int p = 0; p < 2; p++) begin
      if (infl_q[p]) begin
        v_d[p]                   = 1'b1;
        data_d[p*WIDTH +: WIDTH] = mem_data_i;
      end else if (yumi_i[p]) begin
        v_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RST_WAIT;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        RST_WAIT: begin
          clr_cnt_q <= '0;
          state_q   <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
        end
        INIT: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == ADDR_W'(ELS - 1)) begin
            state_q <= RUN;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= RST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
      infl_q <= 2'b00;
      v_q    <= 2'b00;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      infl_q <= infl_d;
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_hard_mem_1rw_arbiter.sv
// Directed bench for hard_mem_1rw_arbiter: clear sequence, arbitration,
// response handshake and reset behaviour, against a small SRAM model.
module tb_hard_mem_1rw_arbiter;

  localparam logic [63:0] D = 64'h1122334455667788;
  localparam logic [63:0] R = 64'h0000000055667788;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [1:0]   v_i, w_i, yumi_i;
  logic [17:0]  addr_i;
  logic [127:0] data_i;
  logic [15:0]  mask_i;
  logic [1:0]   ready_o, v_o;
  logic [127:0] data_o;
  logic         init_done_o;
  logic         mem_v_o, mem_w_o;
  logic [8:0]   mem_addr_o;
  logic [63:0]  mem_data_o;
  logic [7:0]   mem_mask_o;
  logic [63:0]  mem_data_i;

  logic [1:0]   r1_ready, r1_v;
  logic [127:0] r1_data;
  logic         r1_done, r1_mv, r1_mw;
  logic [8:0]   r1_ma;
  logic [63:0]  r1_md;
  logic [7:0]   r1_mm;
  int           r1_mem_cnt = 0;

  int pass_n = 0;
  int tot_n  = 0;

  always #5 clk = ~clk;

  hard_mem_1rw_arbiter #(.ELS(512), .WIDTH(64), .CLEAR_ON_RESET(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i),
    .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
    .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
    .init_done_o(init_done_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i)
  );

  hard_mem_1rw_arbiter #(.ELS(512), .WIDTH(64), .CLEAR_ON_RESET(0)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .v_i(2'b00), .w_i(2'b00),
    .addr_i(18'h0), .data_i(128'h0), .mask_i(16'h0),
    .ready_o(r1_ready), .data_o(r1_data), .v_o(r1_v), .yumi_i(2'b00),
    .init_done_o(r1_done), .mem_v_o(r1_mv), .mem_w_o(r1_mw),
    .mem_addr_o(r1_ma), .mem_data_o(r1_md),
    .mem_mask_o(r1_mm), .mem_data_i(64'h0)
  );

  // SRAM model: masked write, registered read
  logic [63:0] mem [512];
  logic [63:0] rd_q = 64'h0;
  assign mem_data_i = rd_q;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
  end

  always @(posedge clk) begin
    if (mem_v_o && mem_w_o) begin
      for (int b = 0; b < 8; b++)
        if (mem_mask_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
    end else if (mem_v_o) begin
      rd_q <= mem[mem_addr_o];
    end
  end

  always @(posedge clk) if (r1_mv) r1_mem_cnt++;

  typedef struct {
    logic [1:0]  v, w, y;
    logic [8:0]  a0;
    logic [63:0] d0;
    logic [7:0]  m0;
    logic [1:0]  rdy;
    logic        mv, mw;
    logic [8:0]  ma;
    logic [63:0] md;
    logic [7:0]  mm;
    logic [1:0]  vo;
    logic [63:0] o0;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(
    input logic [1:0] v, w, y, input logic [8:0] a0,
    input logic [63:0] d0, input logic [7:0] m0,
    input logic [1:0] rdy, input logic mv, mw, input logic [8:0] ma,
    input logic [63:0] md, input logic [7:0] mm,
    input logic [1:0] vo, input logic [63:0] o0);
    vec_t t;
    t.v = v; t.w = w; t.y = y; t.a0 = a0; t.d0 = d0; t.m0 = m0;
    t.rdy = rdy; t.mv = mv; t.mw = mw; t.ma = ma; t.md = md; t.mm = mm;
    t.vo = vo; t.o0 = o0;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, w, y, input logic [8:0] a0, a1,
                       input logic [63:0] d0, input logic [7:0] m0);
    v_i = v; w_i = w; yumi_i = y;
    addr_i = {a1, a0}; data_i = {64'h0, d0}; mask_i = {8'h0, m0};
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("rst_wait", {init_done_o, mem_v_o, ready_o, r1_done}, '0);
  endtask

  task automatic do_clear(input int n, input bit chk1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk($sformatf("clear[%0d]", i),
          {mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, ready_o,
           init_done_o},
          {1'b1, 1'b1, 9'(i), 64'h0, 8'hFF, 2'b00, 1'b0});
      if (chk1 && i == 0) chk("r1_done", {r1_done}, 1'b1);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {ready_o, v_o, data_o, init_done_o, mem_v_o, mem_w_o,
             mem_addr_o, mem_data_o, mem_mask_o}, '0);
  endtask

  initial begin
    reset_i = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 64'h0, 8'h0);

    tbl[0] = mk(2'b01, 2'b00, 2'b00, 9'd37, 64'h0, 8'h00,
                2'b01, 1, 0, 9'd37, 64'h0, 8'h00, 2'b00, 64'h0);
    tbl[1] = mk(2'b00, 2'b00, 2'b00, 9'd0, 64'h0, 8'h00,
                2'b00, 0, 0, 9'd0, 64'h0, 8'h00, 2'b00, 64'h0);
    tbl[2] = mk(2'b00, 2'b00, 2'b01, 9'd0, 64'h0, 8'h00,
                2'b00, 0, 0, 9'd0, 64'h0, 8'h00, 2'b01, 64'h0);
    tbl[3] = mk(2'b01, 2'b01, 2'b00, 9'd5, D, 8'h0F,
                2'b01, 1, 1, 9'd5, D, 8'h0F, 2'b00, 64'h0);
    tbl[4] = mk(2'b01, 2'b00, 2'b00, 9'd5, 64'h0, 8'h00,
                2'b01, 1, 0, 9'd5, 64'h0, 8'h00, 2'b00, 64'h0);
    tbl[5] = mk(2'b00, 2'b00, 2'b00, 9'd0, 64'h0, 8'h00,
                2'b00, 0, 0, 9'd0, 64'h0, 8'h00, 2'b00, 64'h0);
    tbl[6] = mk(2'b01, 2'b00, 2'b01, 9'd5, 64'h0, 8'h00,
                2'b01, 1, 0, 9'd5, 64'h0, 8'h00, 2'b01, R);
    tbl[7] = mk(2'b00, 2'b00, 2'b00, 9'd0, 64'h0, 8'h00,
                2'b00, 0, 0, 9'd0, 64'h0, 8'h00, 2'b00, R);
    tbl[8] = mk(2'b00, 2'b00, 2'b01, 9'd0, 64'h0, 8'h00,
                2'b00, 0, 0, 9'd0, 64'h0, 8'h00, 2'b01, R);

    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset_state");
    chk("r1_reset", {r1_done, r1_v, r1_ready}, '0);

    // client 0 read of addr 37 held high across the whole clear
    drive(2'b01, 2'b00, 2'b00, 9'd37, 9'd0, 64'h0, 8'h0);
    release_rst();
    do_clear(512, 1'b1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].w, tbl[i].y, tbl[i].a0, 9'd0,
            tbl[i].d0, tbl[i].m0);
      #1;
      chk($sformatf("vec[%0d]", i),
          {ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
           v_o, data_o, init_done_o},
          {tbl[i].rdy, tbl[i].mv, tbl[i].mw, tbl[i].ma, tbl[i].md,
           tbl[i].mm, tbl[i].vo, 64'h0, tbl[i].o0, 1'b1});
    end

    // both clients stream reads with yumi high: grants alternate 1,0,1,0
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] er, ev;
      @(negedge clk);
      drive(2'b11, 2'b00, 2'b11, 9'd5, 9'd5, 64'h0, 8'h0);
      #1;
      er = (k % 2 == 1) ? 2'b10 : 2'b01;
      ev = (k < 3) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("alt[%0d]", k), {ready_o, v_o}, {er, ev});
      if (k >= 3) chk($sformatf("alt_data[%0d]", k), data_o, {R, R});
    end

    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 64'h0, 8'h0);
    #1;
    chk("drain1", {ready_o, v_o}, {2'b00, 2'b10});
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b01, 9'd0, 9'd0, 64'h0, 8'h0);
    #1;
    chk("drain2", {ready_o, v_o, data_o}, {2'b00, 2'b11, R, R});

    // client 1 holds its response; its new reads stall, client 0 writes flow
    for (int k = 0; k < 5; k++) begin
      logic [63:0] wd;
      wd = 64'hC0DE_0000_0000_0000 | 64'(k);
      @(negedge clk);
      drive(2'b11, 2'b01, 2'b00, 9'(100 + k), 9'd7, wd, 8'hFF);
      #1;
      chk($sformatf("hold[%0d]", k),
          {ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, v_o,
           data_o[127:64]},
          {2'b01, 1'b1, 1'b1, 9'(100 + k), wd, 2'b10, R});
    end

    @(negedge clk);
    drive(2'b10, 2'b00, 2'b10, 9'd0, 9'd100, 64'h0, 8'h0);
    #1;
    chk("yumi_gnt", {ready_o, mem_v_o, mem_w_o, mem_addr_o, v_o},
        {2'b10, 1'b1, 1'b0, 9'd100, 2'b10});
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 64'h0, 8'h0);
    #1;
    chk("yumi_gap", {ready_o, v_o}, {2'b00, 2'b00});
    @(negedge clk); #1;
    chk("yumi_resp", {v_o, data_o[127:64]},
        {2'b10, 64'hC0DE_0000_0000_0000});

    // reset in RUN with a pending response
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk_zero("reset_run");

    release_rst();
    do_clear(101, 1'b0);
    reset_i = 1'b1;
    #1;
    chk_zero("reset_init");

    release_rst();
    do_clear(512, 1'b1);
    @(negedge clk); #1;
    chk("post_clear", {init_done_o, mem_v_o, v_o, data_o},
        {1'b1, 1'b0, 2'b00, 128'h0});
    chk("r1_no_mem", 32'(r1_mem_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
